// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern serializer and the detector-side wiring.
package pattern_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int PAT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/pattern_serializer_if.sv
// Word-in / bit-out bus of the pattern serializer.
interface pattern_serializer_if
  import pattern_pkg::*;
#(
  parameter int WIDTH = PAT_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             inbit;
  logic             bit_valid;
  logic             last_bit;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, inbit, bit_valid, last_bit, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, inbit, bit_valid, last_bit, busy
  );
endinterface

// File: rtl/pattern_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in, MSB-first bits out,
// with a one-word hold buffer so consecutive words stream without a gap.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH = PAT_WIDTH_DEFAULT
) (
  input logic                 clk,
  input logic                 rst_n,
  pattern_serializer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sh, sh_d;
  logic [WIDTH-1:0] hold, hold_d;
  logic             hold_full, hold_full_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             accept;
  logic             at_last;

  // The ready depends only on the hold flag, never on in_valid.
  assign bus.in_ready  = !hold_full;
  assign accept        = bus.in_valid && !hold_full;
  assign at_last       = (state_q == SHIFT) && (cnt == LAST);

  assign bus.inbit     = (state_q == SHIFT) ? sh[WIDTH-1] : 1'b0;
  assign bus.bit_valid = (state_q == SHIFT);
  assign bus.last_bit  = at_last;
  assign bus.busy      = (state_q == SHIFT) || hold_full;

  // Next-state and datapath: a free shifter always takes the accepted word,
  // otherwise it parks in hold until the current word's last bit.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh;
    cnt_d       = cnt;
    hold_d      = hold;
    hold_full_d = hold_full;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = bus.in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!at_last) begin
          sh_d  = sh << 1;
          cnt_d = cnt + CW'(1);
          if (accept) begin
            hold_d      = bus.in_data;
            hold_full_d = 1'b1;
          end
        end else if (hold_full) begin
          sh_d        = hold;
          cnt_d       = '0;
          hold_full_d = 1'b0;
        end else if (accept) begin
          // bypass: new word goes straight into the shifter, no gap bit
          sh_d  = bus.in_data;
          cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sh        <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh        <= sh_d;
      cnt       <= cnt_d;
      hold      <= hold_d;
      hold_full <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Bench for pattern_serializer: directed scenarios plus random traffic,
// checked every cycle against a bit-queue model of the serial stream.
module tb_pattern_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pattern_serializer_if #(.WIDTH(W)) bus ();

  pattern_serializer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: every accepted word appends its bits to a queue; one bit
  // leaves per cycle. Anything beyond one word's worth is the hold buffer.
  bit          mq[$];
  bit          last_acc;
  logic [63:0] cap;
  int          ncap;
  bit          saw_not_ready;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit acc;
    int rem;
    @(posedge clk);
    last_acc = 1'b0;
    if (!rst_n) begin
      mq.delete();
    end else begin
      acc = bus.in_valid && (mq.size() <= W);
      if (mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        for (int i = W - 1; i >= 0; i--) mq.push_back(bus.in_data[i]);
        last_acc = 1'b1;
      end
    end
    #1;
    rem = (mq.size() > W) ? mq.size() - W : mq.size();
    chk("bit_valid", 64'(bus.bit_valid), 64'(mq.size() > 0));
    chk("inbit",     64'(bus.inbit),     64'((mq.size() > 0) ? mq[0] : 1'b0));
    chk("last_bit",  64'(bus.last_bit),  64'(mq.size() > 0 && rem == 1));
    chk("busy",      64'(bus.busy),      64'(mq.size() > 0));
    chk("in_ready",  64'(bus.in_ready),  64'(mq.size() <= W));
    if (bus.bit_valid === 1'b1) begin
      cap = {cap[62:0], bus.inbit};
      ncap++;
    end
    if (bus.in_ready !== 1'b1) saw_not_ready = 1'b1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clr();
    cap = '0;
    ncap = 0;
    saw_not_ready = 1'b0;
  endtask

  // Holds in_valid with the given word until it is taken (bounded).
  task automatic offer(input logic [W-1:0] d);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    do begin
      cycle();
      t++;
    end while (!last_acc && t < 40);
    chk("accept_timeout", 64'(last_acc), 64'(1));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clr();

    // reset state and idle fill
    run(2);
    rst_n = 1'b1;
    clr();
    run(20);
    chk("idle_bits", 64'(ncap), 64'(0));

    // single word
    clr();
    offer(8'hA5);
    bus.in_valid = 1'b0;
    run(10);
    chk("single_stream", cap, 64'hA5);
    chk("single_count",  64'(ncap), 64'(8));

    // back-to-back, second word queued into hold
    clr();
    offer(8'hA5);
    offer(8'h3C);
    bus.in_valid = 1'b0;
    run(20);
    chk("b2b_stream", cap, 64'hA53C);
    chk("b2b_count",  64'(ncap), 64'(16));
    chk("b2b_ready_dropped", 64'(saw_not_ready), 64'(1));

    // backpressure with valid held across three words
    clr();
    offer(8'h01);
    offer(8'h80);
    offer(8'hFF);
    bus.in_valid = 1'b0;
    run(30);
    chk("bp_stream", cap, 64'h0180FF);
    chk("bp_count",  64'(ncap), 64'(24));

    // bypass exactly at the last-bit edge
    clr();
    offer(8'h0F);
    bus.in_valid = 1'b0;
    run(7);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hF0;
    cycle();
    chk("bypass_taken", 64'(last_acc), 64'(1));
    bus.in_valid = 1'b0;
    run(12);
    chk("bypass_stream", cap, 64'h0FF0);
    chk("bypass_count",  64'(ncap), 64'(16));
    chk("bypass_no_hold", 64'(saw_not_ready), 64'(0));

    // reset mid-word with a word waiting in hold
    offer(8'hFF);
    offer(8'h55);
    bus.in_valid = 1'b0;
    run(1);
    rst_n = 1'b0;
    cycle();
    chk("rst_bit_valid", 64'(bus.bit_valid), 64'(0));
    chk("rst_in_ready",  64'(bus.in_ready),  64'(1));
    rst_n = 1'b1;
    clr();
    run(20);
    chk("rst_residual", 64'(ncap), 64'(0));

    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = W'($urandom);
      rst_n        = ($urandom_range(0, 99) != 0);
      cycle();
    end
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    run(20);
    chk("drain_empty", 64'(bus.busy), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
# pattern_serializer

Parallel-to-serial front end for the Moore pattern-detector stage. It accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per `clk` cycle, on `inbit`, which drives the detector's `inbit` input directly. A one-word hold buffer lets the next word be queued while the current one shifts, so back-to-back words stream with no gap bit.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is WIDTH ≥ 2.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_data`  in  WIDTH: word to serialize; sampled when `in_valid && in_ready`.
- `in_valid`  in  1: the upstream source offers `in_data`.
- `in_ready`  out  1: the block can accept a word this cycle.
- `inbit`  out  1: serial bit to the detector; MSB first.
- `bit_valid`  out  1: `inbit` carries a data bit this cycle.
- `last_bit`  out  1: `inbit` is the LSB of the current word.
- `busy`  out  1: the shifter or the hold buffer is occupied.

## Operation
- Storage:
  - Shift register `sh[WIDTH-1:0]`.
  - Bit counter `cnt` of width $clog2(WIDTH).
  - Hold register `hold[WIDTH-1:0]` with flag `hold_full`.
- FSM states:
  - IDLE: the shifter is empty.
  - SHIFT: `sh` holds a word being emitted.
- Outputs:
  - `inbit = sh[WIDTH-1]` in SHIFT; `inbit = 0` in IDLE, so the detector sees 0-fill bits.
  - `bit_valid = (state == SHIFT)`.
  - `last_bit = (state == SHIFT) && (cnt == WIDTH-1)`.
  - `in_ready = !hold_full`. It is a combinational function of a register and never depends on `in_valid`.
  - `busy = (state == SHIFT) || hold_full`.
- An accepted word always goes to the shifter if the shifter is free at that edge. Otherwise it goes to the hold buffer.
- IDLE, word accepted: `sh <= in_data`, `cnt <= 0`, next state SHIFT.
- SHIFT, not the last bit: `sh <= sh << 1`, `cnt <= cnt + 1`. If a word is accepted, `hold <= in_data` and `hold_full <= 1`.
- SHIFT, last bit (`cnt == WIDTH-1`):
  - hold_full: `sh <= hold`, `cnt <= 0`, `hold_full <= 0`, stay in SHIFT. No word is accepted this edge because `in_ready = 0`.
  - hold empty, word accepted: `sh <= in_data`, `cnt <= 0`, stay in SHIFT (bypass path).
  - hold empty, no word: go to IDLE.
- Word order is strictly preserved. Each word emits exactly WIDTH bits, and no bit is dropped or duplicated.
- Reset, with `rst_n` = 0 at an edge, applies regardless of state and mid-word. It discards the shifter and hold contents and sets state = IDLE, `cnt` = 0, `hold_full` = 0, `sh` = 0. Reset takes priority over any handshake in the same cycle.

## Timing
- Values of all outputs in the cycle after reset:
  - `inbit` = 0, `bit_valid` = 0, `last_bit` = 0, `busy` = 0.
  - `in_ready` = 1.
- Latency: a word accepted at edge k in IDLE drives its MSB on `inbit` during cycle k+1 and its LSB during cycle k+WIDTH.
- Throughput: one bit per cycle. Sustained 100% `bit_valid` is possible if the next word is accepted before or at the last-bit edge of the current one.
- In IDLE, the earliest time a second word can be accepted is the cycle after the first. It lands in hold, and `in_ready` drops in the following cycle.
- `in_ready` returns to 1 in the cycle after the hold word moves into the shifter.
- Handshake:
  - `in_data` need only be stable in the cycle where `in_valid && in_ready`.
  - The source may deassert `in_valid` at any time.
  - The block never accepts a word when `in_ready` = 0.

## Structure
- Shared package `pattern_pkg`:
  - State enum {IDLE, SHIFT}.
  - Constant `PAT_WIDTH_DEFAULT = 8`. It is shared with the detector-side wiring.
- No sub-module: the shifter, counter, hold buffer and FSM sit in one module.

## Test plan
- Single word: after reset, offer 8'hA5 once → `inbit` = 1,0,1,0,0,1,0,1 in cycles 1–8. `last_bit` is high in cycle 8 only. `bit_valid` is low from cycle 9.
- Back-to-back: 8'hA5 at edge 0, then 8'h3C offered from edge 1 → 16 consecutive `bit_valid` cycles with `inbit` = 1010010100111100. `in_ready` is 0 from cycle 2 until the cycle after the hold moves into the shifter.
- Backpressure: hold `in_valid` high with three words 8'h01, 8'h80, 8'hFF → the third word is accepted only after 8'h01 finishes. The serial stream is the exact concatenation of the three words.
- Bypass at the boundary: hold empty, and 8'hF0 offered exactly at the last-bit edge of 8'h0F → the stream is 0000111111110000 with no gap cycle and `hold_full` never set.
- Reset mid-word: assert `rst_n` = 0 at bit 3 of 8'hFF with a word in hold → the next cycle shows `bit_valid` = 0, `inbit` = 0, `in_ready` = 1, `busy` = 0. No residual bits appear after reset release.
- Idle fill: no input for 20 cycles after reset → `inbit` = 0 and `bit_valid` = 0 throughout.
